// File: rtl/program_loader_pkg.sv
// Shared loader types: FSM states, error codes and the default frame marker.
package common;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    CSUM,
    RUN,
    ERROR
  } loader_state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_LEN     = 2'd1,
    ERR_CSUM    = 2'd2,
    ERR_TIMEOUT = 2'd3
  } loader_err_t;

  localparam logic [7:0] LOADER_SYNC_BYTE = 8'hA5;

  function automatic logic is_loading(loader_state_t s);
    return s inside {LEN, DATA, CSUM};
  endfunction

endpackage

// File: rtl/program_loader_watchdog.sv
// Inter-byte idle watchdog: expired pulses on the TIMEOUT_CYCLES-th consecutive
// enabled cycle without a kick; the count restarts on kick, disable or expiry.
module loader_watchdog #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic kick,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    expired = enable && !kick && (count_q == LAST);
    count_d = (kick || !enable || expired) ? '0 : count_q + CW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

endmodule

// File: rtl/program_loader.sv
// Framed boot loader: sync, little-endian length, payload words, 8-bit additive
// checksum. Owns the program-memory write port and grants run only on a good frame.
module program_loader
  import common::*;
#(
  parameter int          WORD_BYTES     = 4,
  parameter int          ADDR_WIDTH     = 32,
  parameter int          MAX_WORDS      = 1024,
  parameter int          LEN_BYTES      = 2,
  parameter logic [7:0]  SYNC_BYTE      = LOADER_SYNC_BYTE,
  parameter int unsigned BASE_ADDR      = 0,
  parameter int          TIMEOUT_CYCLES = 1000000
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           rx_valid,
  input  logic [7:0]                     rx_byte,
  input  logic                           run_finished,
  output logic                           mem_we,
  output logic [ADDR_WIDTH-1:0]          mem_addr,
  output logic [8*WORD_BYTES-1:0]        mem_wdata,
  output logic                           run,
  output logic                           loading,
  output logic                           error,
  output logic [1:0]                     error_code,
  output logic [$clog2(MAX_WORDS+1)-1:0] words_loaded
);

  localparam int DATA_W = 8 * WORD_BYTES;
  localparam int LEN_W  = 8 * LEN_BYTES;
  localparam int WL_W   = $clog2(MAX_WORDS + 1);
  localparam int BI_W   = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int LI_W   = (LEN_BYTES > 1) ? $clog2(LEN_BYTES) : 1;
  localparam int CMP_W  = (LEN_W > 32) ? LEN_W : 32;
  localparam logic [BI_W-1:0] LAST_BYTE = BI_W'(WORD_BYTES - 1);
  localparam logic [LI_W-1:0] LAST_LEN  = LI_W'(LEN_BYTES - 1);

  loader_state_t         state_q, state_d;
  loader_err_t           err_set, err_code_d, err_code_q;
  logic [LEN_W-1:0]      len_q, len_next;
  logic [LI_W-1:0]       len_idx_q;
  logic [BI_W-1:0]       byte_idx_q;
  logic [DATA_W-1:0]     word_q, word_next;
  logic [7:0]            csum_q;
  logic [WL_W-1:0]       words_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q, word_addr;
  logic [DATA_W-1:0]     mem_wdata_q;
  logic                  run_q, run_d, loading_q, loading_d, error_q, error_d;
  logic                  expired, sync_hit, len_done, len_bad, word_done, frame_done, start;

  loader_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (loading_q),
    .kick    (rx_valid),
    .expired (expired)
  );

  // Both assemblers shift right so the first byte received lands in bits [7:0].
  always_comb begin
    len_next   = LEN_W'({rx_byte, len_q} >> 8);
    word_next  = DATA_W'({rx_byte, word_q} >> 8);
    sync_hit   = rx_valid && (rx_byte == SYNC_BYTE);
    len_done   = rx_valid && (len_idx_q == LAST_LEN);
    len_bad    = (len_next == '0) || (CMP_W'(len_next) > CMP_W'(MAX_WORDS));
    word_done  = rx_valid && (byte_idx_q == LAST_BYTE);
    frame_done = (CMP_W'(words_q) + CMP_W'(1)) == CMP_W'(len_q);
    word_addr  = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(words_q) * ADDR_WIDTH'(WORD_BYTES);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      err_code_q <= ERR_NONE;
      run_q      <= 1'b0;
      loading_q  <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      err_code_q <= err_code_d;
      run_q      <= run_d;
      loading_q  <= loading_d;
      error_q    <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    err_set = ERR_NONE;
    unique case (state_q)
      IDLE:  if (sync_hit) state_d = LEN;
      LEN: begin
        if (expired) begin
          state_d = ERROR;
          err_set = ERR_TIMEOUT;
        end else if (len_done) begin
          state_d = len_bad ? ERROR : DATA;
          err_set = len_bad ? ERR_LEN : ERR_NONE;
        end
      end
      DATA: begin
        if (expired) begin
          state_d = ERROR;
          err_set = ERR_TIMEOUT;
        end else if (word_done && frame_done) begin
          state_d = CSUM;
        end
      end
      CSUM: begin
        if (expired) begin
          state_d = ERROR;
          err_set = ERR_TIMEOUT;
        end else if (rx_valid) begin
          state_d = (rx_byte == csum_q) ? RUN : ERROR;
          err_set = (rx_byte == csum_q) ? ERR_NONE : ERR_CSUM;
        end
      end
      RUN:   if (run_finished) state_d = IDLE;
      ERROR: if (sync_hit) state_d = LEN;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every one of them is a flop.
  always_comb begin
    run_d      = (state_d == RUN);
    loading_d  = is_loading(state_d);
    error_d    = (state_d == ERROR);
    err_code_d = ERR_NONE;
    if (state_d == ERROR) err_code_d = (state_q == ERROR) ? err_code_q : err_set;
    start      = (state_q == IDLE || state_q == ERROR) && (state_d == LEN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len_q       <= '0;
      len_idx_q   <= '0;
      byte_idx_q  <= '0;
      word_q      <= '0;
      csum_q      <= '0;
      words_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= ADDR_WIDTH'(BASE_ADDR);
      mem_wdata_q <= '0;
    end else begin
      mem_we_q <= 1'b0;
      if (start) begin
        len_q      <= '0;
        len_idx_q  <= '0;
        byte_idx_q <= '0;
        word_q     <= '0;
        csum_q     <= '0;
        words_q    <= '0;
      end
      if (state_q == LEN && rx_valid) begin
        len_q     <= len_next;
        len_idx_q <= len_idx_q + LI_W'(1);
      end
      if (state_q == DATA && rx_valid) begin
        csum_q     <= csum_q + rx_byte;
        word_q     <= word_next;
        byte_idx_q <= word_done ? '0 : byte_idx_q + BI_W'(1);
        if (word_done) begin
          mem_we_q    <= 1'b1;
          mem_addr_q  <= word_addr;
          mem_wdata_q <= word_next;
          words_q     <= words_q + WL_W'(1);
        end
      end
    end
  end

  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign run          = run_q;
  assign loading      = loading_q;
  assign error        = error_q;
  assign error_code   = err_code_q;
  assign words_loaded = words_q;

endmodule
